axi_wr_arbiter: RTL
===================

Name: axi_wr_arbiter

Overview:
Two-requester scheduler for the shared AXI write path between the write master and write slave.
- Accepts burst write requests (AW parameters plus W stream) from two local clients.
- Grants one client per burst, round-robin. Sequences the AW, W and B phases on the master-side AXI write signals.
- Generates WLAST from a beat counter and returns the B response to the granted client.

Parameters:
AW, 32, address width
DW, 64, write data width (strobe width DW/8)
NREQ, 2, number of requesters (fixed at 2 in this revision)

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
req_valid  in  2  per-client burst request pending
req_addr  in  2*AW  per-client start address, client i at [i*AW +: AW]
req_len  in  16  per-client awlen, 8b each
req_size  in  6  per-client awsize, 3b each
req_burst  in  4  per-client awburst, 2b each
req_ready  out  2  one-cycle accept pulse; request latched
req_wdata  in  2*DW  per-client write data
req_wstrb  in  2*DW/8  per-client strobes
req_wvalid  in  2  per-client beat valid
req_wready  out  2  per-client beat ready
req_bvalid  out  2  one-cycle response pulse to granted client
req_bresp  out  2  response code, valid with req_bvalid
m_awaddr, m_awlen, m_awsize, m_awburst  out  AW/8/3/2  latched burst parameters
m_awvalid  out  1  address valid
m_awready  in  1  address ready
m_wdata, m_wstrb  out  DW, DW/8  forwarded beat
m_wlast  out  1  final beat of burst
m_wvalid  out  1  beat valid
m_wready  in  1  beat ready
m_bresp  in  2  write response
m_bvalid  in  1  response valid
m_bready  out  1  response ready
grant_id  out  1  currently/last granted client
busy  out  1  state != IDLE

Behaviour:
- FSM states: IDLE, ADDR, DATA, RESP.
- Reset: async on resetn low. State IDLE, rr_last=1 (client 0 wins first), beat counter 0.
  - All outputs 0 at reset: m_awvalid, m_wvalid, m_wlast, m_bready, req_ready, req_bvalid, req_bresp, m_aw* registers, grant_id, busy.
  - A reset mid-burst abandons the transaction; no response is delivered to the client.
- IDLE, any req_valid set:
  - Pick the client: if both are valid, pick the one != rr_last; otherwise pick the sole valid client.
  - Latch its addr/len/size/burst into m_aw* and set grant_id and rr_last.
  - Pulse req_ready[g] for exactly 1 cycle. Next state ADDR.
- ADDR: m_awvalid=1. m_aw* stay stable until the m_awready handshake. On handshake: clear the beat counter, go to DATA.
  - W beats are never forwarded before the AW handshake completes.
- DATA:
  - m_wvalid=req_wvalid[g]; m_wdata/m_wstrb come from client g (combinational mux).
  - req_wready[g]=m_wready; the other client's wready=0.
  - m_wlast=(cnt==m_awlen) while in DATA.
  - Each wvalid&&wready increments cnt (8b). The beat handshake with m_wlast goes to RESP.
  - awlen=0 gives a single beat with wlast set.
- RESP: m_bready=1. On m_bvalid: pulse req_bvalid[g] for 1 cycle with req_bresp=m_bresp, go to IDLE.
  - Clients cannot backpressure B.
- Re-arbitration happens only in IDLE: minimum 1 idle cycle between bursts.
  - A req_valid change during ADDR/DATA/RESP is ignored.
  - A client that deasserts req_valid before its grant is simply not picked.
- Simultaneous m_bvalid and a new req_valid: the response completes first; the new request is granted on the following IDLE cycle.
- busy=1 in ADDR/DATA/RESP.

Decomposition:
- Package axi_wr_arb_pkg:
  - state enum {IDLE, ADDR, DATA, RESP}
  - NREQ=2
  - AXI burst codes FIXED=0, INCR=1, WRAP=2
  - response codes OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3
- Sub-module wr_rr_picker: combinational 2-way round-robin choice from req_valid and rr_last. Outputs gnt_valid and gnt_id.

Test Plan:
- Client0 alone, addr=0x1000, len=3, size=3, INCR, awready/wready always 1, bresp=OKAY -> m_awvalid 1 cycle; 4 beats with m_wlast on the 4th; req_bvalid[0] pulse with bresp=0.
- Both clients request in the same cycle, repeated 4 times -> grant order 0,1,0,1; req_ready pulses alternate.
- len=0, m_wready low 3 cycles -> m_wvalid held; single beat with m_wlast=1; then RESP.
- m_awready low 5 cycles -> m_awaddr/len stable, no m_wvalid asserted during ADDR.
- resetn low mid-DATA after 2 of 8 beats -> all outputs 0 asynchronously; after release, client0 wins first; no stale req_bvalid.
- Client1 bursts of len=7 with m_bresp=SLVERR and m_bvalid delayed 4 cycles -> m_bready held; req_bvalid[1] pulse with bresp=2; req_bvalid[0] stays 0.

Source files
------------

// File: rtl/axi_wr_arb_pkg.sv
// Shared types and constants for the two-client AXI write-path arbiter.
package axi_wr_arb_pkg;

   localparam int NREQ = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2,
      RESP = 2'd3
   } state_e;

   localparam logic [1:0] BURST_FIXED = 2'd0;
   localparam logic [1:0] BURST_INCR  = 2'd1;
   localparam logic [1:0] BURST_WRAP  = 2'd2;

   localparam logic [1:0] RESP_OKAY   = 2'd0;
   localparam logic [1:0] RESP_EXOKAY = 2'd1;
   localparam logic [1:0] RESP_SLVERR = 2'd2;
   localparam logic [1:0] RESP_DECERR = 2'd3;

endpackage

// File: rtl/wr_rr_picker.sv
// Combinational 2-way round-robin choice: on a tie the client that did not win last time is picked.
module wr_rr_picker
   import axi_wr_arb_pkg::*;
(
   input  logic [NREQ-1:0] req_valid,
   input  logic            rr_last,
   output logic            gnt_valid,
   output logic            gnt_id
);

   always_comb begin
      gnt_valid = |req_valid;
      if (&req_valid) gnt_id = ~rr_last;
      else            gnt_id = req_valid[1];
   end

endmodule

// File: rtl/axi_wr_arbiter.sv
// Schedules one burst at a time from two clients onto the master-side AXI write channels
// (AW, then W with counter-generated WLAST, then B routed back to the granted client).
module axi_wr_arbiter
   import axi_wr_arb_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 64
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [NREQ*AW-1:0]   req_addr,
   input  logic [NREQ*8-1:0]    req_len,
   input  logic [NREQ*3-1:0]    req_size,
   input  logic [NREQ*2-1:0]    req_burst,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*DW-1:0]   req_wdata,
   input  logic [NREQ*DW/8-1:0] req_wstrb,
   input  logic [NREQ-1:0]      req_wvalid,
   output logic [NREQ-1:0]      req_wready,
   output logic [NREQ-1:0]      req_bvalid,
   output logic [1:0]           req_bresp,
   output logic [AW-1:0]        m_awaddr,
   output logic [7:0]           m_awlen,
   output logic [2:0]           m_awsize,
   output logic [1:0]           m_awburst,
   output logic                 m_awvalid,
   input  logic                 m_awready,
   output logic [DW-1:0]        m_wdata,
   output logic [DW/8-1:0]      m_wstrb,
   output logic                 m_wlast,
   output logic                 m_wvalid,
   input  logic                 m_wready,
   input  logic [1:0]           m_bresp,
   input  logic                 m_bvalid,
   output logic                 m_bready,
   output logic                 grant_id,
   output logic                 busy
);

   state_e          state, state_nxt;
   logic            rr_last;
   logic [7:0]      cnt;
   logic            gnt_valid, gnt_id;
   logic            w_hs;

   logic [AW-1:0]   c_addr  [NREQ];
   logic [7:0]      c_len   [NREQ];
   logic [2:0]      c_size  [NREQ];
   logic [1:0]      c_burst [NREQ];
   logic [DW-1:0]   c_wdata [NREQ];
   logic [DW/8-1:0] c_wstrb [NREQ];

   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         c_addr[i]  = req_addr[i*AW +: AW];
         c_len[i]   = req_len[i*8 +: 8];
         c_size[i]  = req_size[i*3 +: 3];
         c_burst[i] = req_burst[i*2 +: 2];
         c_wdata[i] = req_wdata[i*DW +: DW];
         c_wstrb[i] = req_wstrb[i*(DW/8) +: DW/8];
      end
   end

   wr_rr_picker u_picker (
      .req_valid (req_valid),
      .rr_last   (rr_last),
      .gnt_valid (gnt_valid),
      .gnt_id    (gnt_id)
   );

   assign w_hs = m_wvalid && m_wready;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (gnt_valid)         state_nxt = ADDR;
         ADDR: if (m_awready)         state_nxt = DATA;
         DATA: if (w_hs && m_wlast)   state_nxt = RESP;
         RESP: if (m_bvalid)          state_nxt = IDLE;
         default:                     state_nxt = IDLE;
      endcase
   end

   // NOTE: registered state uses <= so every flop samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rr_last    <= 1'b1;
         grant_id   <= 1'b0;
         cnt        <= '0;
         m_awaddr   <= '0;
         m_awlen    <= '0;
         m_awsize   <= '0;
         m_awburst  <= '0;
         req_ready  <= '0;
         req_bvalid <= '0;
         req_bresp  <= '0;
      end else begin
         req_ready  <= '0;
         req_bvalid <= '0;
         req_bresp  <= '0;
         if (state == IDLE && gnt_valid) begin
            grant_id  <= gnt_id;
            rr_last   <= gnt_id;
            m_awaddr  <= c_addr[gnt_id];
            m_awlen   <= c_len[gnt_id];
            m_awsize  <= c_size[gnt_id];
            m_awburst <= c_burst[gnt_id];
            req_ready <= NREQ'(1) << gnt_id;
         end
         if (state == ADDR && m_awready) cnt <= '0;
         else if (w_hs)                  cnt <= cnt + 8'd1;
         if (state == RESP && m_bvalid) begin
            req_bvalid <= NREQ'(1) << grant_id;
            req_bresp  <= m_bresp;
         end
      end
   end

   // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
   always_comb begin
      m_awvalid  = 1'b0;
      m_wvalid   = 1'b0;
      m_wdata    = '0;
      m_wstrb    = '0;
      m_wlast    = 1'b0;
      m_bready   = 1'b0;
      req_wready = '0;
      busy       = (state != IDLE);
      unique case (state)
         ADDR: m_awvalid = 1'b1;
         DATA: begin
            m_wvalid             = req_wvalid[grant_id];
            m_wdata              = c_wdata[grant_id];
            m_wstrb              = c_wstrb[grant_id];
            m_wlast              = (cnt == m_awlen);
            req_wready[grant_id] = m_wready;
         end
         RESP: m_bready = 1'b1;
         default: ;
      endcase
   end

endmodule
